// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding access, byte/half/word
// with sign/zero extension, alignment checks and an ack timeout.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_we,
    input  logic [2:0]  in_ctr,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rd,
    output logic        out_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         ctr_q, ctr_d;
    logic [1:0]         off_q, off_d;

    logic               ready_d, valid_d, err_d, req_d, we_d;
    logic [31:0]        rd_d, addr_d, wdata_d;
    logic [3:0]         wstrb_d;

    logic               req_bad;
    logic [3:0]         st_strb;
    logic [31:0]        st_data;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_ext;

    // Decode incoming request: legality, alignment, store lane placement
    always_comb begin
        req_bad = 1'b0;
        st_strb = 4'b1111;
        st_data = in_wd;
        case (in_ctr)
            3'b000, 3'b100: req_bad = 1'b0;
            3'b001, 3'b101: req_bad = in_addr[0];
            3'b010:         req_bad = (in_addr[1:0] != 2'b00);
            default:        req_bad = 1'b1;
        endcase
        case (in_ctr[1:0])
            2'b00: begin
                st_strb = 4'b0001 << in_addr[1:0];
                st_data = {4{in_wd[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << in_addr[1:0];
                st_data = {2{in_wd[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = in_wd;
            end
        endcase
    end

    // Select and extend the loaded lane from the returned word
    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (off_q)
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ctr_q[1:0])
            2'b00:   ld_ext = {{24{ld_byte[7] & ~ctr_q[2]}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_half[15] & ~ctr_q[2]}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctr_d   = ctr_q;
        off_d   = off_q;
        ready_d = in_ready;
        valid_d = out_valid;
        rd_d    = out_rd;
        err_d   = out_err;
        req_d   = mem_req;
        we_d    = mem_we;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        wstrb_d = mem_wstrb;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ready_d = 1'b0;
                    ctr_d   = in_ctr;
                    off_d   = in_addr[1:0];
                    if (req_bad) begin
                        state_d = RESP;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        rd_d    = 32'd0;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = in_we;
                        addr_d  = {in_addr[31:2], 2'b00};
                        wdata_d = st_data;
                        wstrb_d = in_we ? st_strb : 4'b0000;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    rd_d    = mem_we ? 32'd0 : ld_ext;
                end else if (cnt_q + CNT_W'(1) == CNT_LIMIT) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    rd_d    = 32'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ctr_q     <= 3'd0;
            off_q     <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_rd    <= 32'd0;
            out_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctr_q     <= ctr_d;
            off_q     <= off_d;
            in_ready  <= ready_d;
            out_valid <= valid_d;
            out_rd    <= rd_d;
            out_err   <= err_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_wstrb <= wstrb_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed table, random traffic
// against a byte-level reference model, and reset/ack corner sequences.
module tb_lsu_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_we;
    logic [2:0]  in_ctr;
    logic [31:0] in_addr, in_wd;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_we     (in_we),
        .in_ctr    (in_ctr),
        .in_addr   (in_addr),
        .in_wd     (in_wd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd),
        .out_err   (out_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  ctr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          delay;
        int          rdy;
        logic        err;
        logic [31:0] rd;
        int          reqs;
        logic [31:0] maddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bytes picked out by offset and size, sign applied arithmetically
    function automatic void model(input logic we, input logic [2:0] ctr,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rdata, input int delay,
                                  output logic err, output logic [31:0] rd,
                                  output int reqs, output logic [3:0] wstrb,
                                  output logic [31:0] wdata);
        int     size;
        int     off;
        logic   legal;
        longint v;
        legal = (ctr == 3'b000) || (ctr == 3'b001) || (ctr == 3'b010) ||
                (ctr == 3'b100) || (ctr == 3'b101);
        size  = (ctr[1:0] == 2'b00) ? 1 : (ctr[1:0] == 2'b01) ? 2 : 4;
        off   = int'(addr[1:0]);
        rd    = 32'd0;
        for (int i = 0; i < 4; i++) begin
            wstrb[i] = we && (i >= off) && (i < off + size);
            wdata[8*i +: 8] = wd[8*(i % size) +: 8];
        end
        if (!legal || (off % size) != 0) begin
            err  = 1'b1;
            reqs = 0;
        end else if (delay >= int'(TO)) begin
            err  = 1'b1;
            reqs = int'(TO);
        end else begin
            err  = 1'b0;
            reqs = delay + 1;
            if (!we) begin
                v = 0;
                for (int j = 0; j < size; j++)
                    v = v | (longint'(rdata[8*(off+j) +: 8]) << (8*j));
                if (!ctr[2] && size < 4 && v[8*size-1])
                    v = v - (longint'(1) << (8*size));
                rd = 32'(v);
            end
        end
    endfunction

    // One full request/response exchange with per-cycle checks
    task automatic run(input vec_t v, input string tag);
        int k;
        int reqs;
        @(negedge clk);
        chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_we = v.we; in_ctr = v.ctr; in_addr = v.addr; in_wd = v.wd;
        @(negedge clk);
        in_valid = 1'b0; in_we = 1'($urandom); in_ctr = 3'($urandom);
        in_addr = $urandom; in_wd = $urandom;
        chk({tag, "/in_ready_busy"}, 32'(in_ready), 32'd0);
        k = 0; reqs = 0;
        while (!out_valid && k < 40) begin
            if (mem_req) begin
                reqs++;
                chk({tag, "/mem_addr"}, mem_addr, v.maddr);
                chk({tag, "/mem_we"}, 32'(mem_we), 32'(v.we));
                chk({tag, "/mem_wstrb"}, 32'(mem_wstrb), 32'(v.wstrb));
                if (v.we) chk({tag, "/mem_wdata"}, mem_wdata, v.wdata);
            end
            if (k == v.delay) begin
                mem_ack = 1'b1; mem_rdata = v.rdata;
            end else begin
                mem_ack = 1'b0; mem_rdata = $urandom;
            end
            @(negedge clk);
            k++;
        end
        mem_ack = 1'b0;
        chk({tag, "/out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "/req_cycles"}, 32'(reqs), 32'(v.reqs));
        chk({tag, "/mem_req_off"}, 32'(mem_req), 32'd0);
        chk({tag, "/out_err"}, 32'(out_err), 32'(v.err));
        chk({tag, "/out_rd"}, out_rd, v.rd);
        for (int w = 0; w < v.rdy; w++) begin
            mem_ack = 1'($urandom); mem_rdata = $urandom;
            @(negedge clk);
            chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "/hold_rd"}, out_rd, v.rd);
            chk({tag, "/hold_err"}, 32'(out_err), 32'(v.err));
            chk({tag, "/hold_req"}, 32'(mem_req), 32'd0);
        end
        mem_ack = 1'b0;
        chk({tag, "/ready_in_resp"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/consumed"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vec_t rv;
        rst_n = 1'b0; in_valid = 1'b0; in_we = 1'b0; in_ctr = 3'd0;
        in_addr = 32'd0; in_wd = 32'd0; out_ready = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'd0;

        tbl[0]  = '{1'b0, 3'b000, 32'h80000003, 32'h0, 32'h80FF1234, 0, 0, 1'b0, 32'hFFFFFF80, 1, 32'h80000000, 4'h0, 32'h0};
        tbl[1]  = '{1'b0, 3'b101, 32'h80000002, 32'h0, 32'h8001ABCD, 3, 3, 1'b0, 32'h00008001, 4, 32'h80000000, 4'h0, 32'h0};
        tbl[2]  = '{1'b1, 3'b000, 32'h00000010, 32'hA5, 32'h0, 0, 1, 1'b0, 32'h0, 1, 32'h10, 4'b0001, 32'hA5A5A5A5};
        tbl[3]  = '{1'b1, 3'b000, 32'h00000012, 32'h123456A5, 32'h0, 1, 0, 1'b0, 32'h0, 2, 32'h10, 4'b0100, 32'hA5A5A5A5};
        tbl[4]  = '{1'b0, 3'b010, 32'h00000006, 32'h0, 32'h0, 0, 1, 1'b1, 32'h0, 0, 32'h0, 4'h0, 32'h0};
        tbl[5]  = '{1'b0, 3'b010, 32'h00000100, 32'h0, 32'hDEADBEEF, 2, 0, 1'b0, 32'hDEADBEEF, 3, 32'h100, 4'h0, 32'h0};
        tbl[6]  = '{1'b1, 3'b001, 32'h00000022, 32'hFFFF8765, 32'h0, 0, 0, 1'b0, 32'h0, 1, 32'h20, 4'b1100, 32'h87658765};
        tbl[7]  = '{1'b0, 3'b001, 32'h00000041, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 0, 32'h0, 4'h0, 32'h0};
        tbl[8]  = '{1'b0, 3'b011, 32'h00000040, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 0, 32'h0, 4'h0, 32'h0};
        tbl[9]  = '{1'b1, 3'b110, 32'h00000040, 32'h1, 32'h0, 0, 0, 1'b1, 32'h0, 0, 32'h0, 4'h0, 32'h0};
        tbl[10] = '{1'b0, 3'b111, 32'h00000044, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 0, 32'h0, 4'h0, 32'h0};
        tbl[11] = '{1'b0, 3'b000, 32'h00000200, 32'h0, 32'h12345678, 7, 1, 1'b1, 32'h0, 4, 32'h200, 4'h0, 32'h0};
        tbl[12] = '{1'b0, 3'b100, 32'h00000201, 32'h0, 32'h0000F100, 0, 0, 1'b0, 32'h000000F1, 1, 32'h200, 4'h0, 32'h0};
        tbl[13] = '{1'b0, 3'b001, 32'h00000302, 32'h0, 32'h9ABC0000, 0, 0, 1'b0, 32'hFFFF9ABC, 1, 32'h300, 4'h0, 32'h0};
        tbl[14] = '{1'b1, 3'b010, 32'h00000300, 32'h11223344, 32'h0, 3, 0, 1'b0, 32'h0, 4, 32'h300, 4'hF, 32'h11223344};
        tbl[15] = '{1'b1, 3'b010, 32'h00000000, 32'h55, 32'h0, 5, 0, 1'b1, 32'h0, 4, 32'h0, 4'hF, 32'h00000055};

        // Values while reset is held
        #12;
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/out_err", 32'(out_err), 32'd0);
        chk("rst/out_rd", out_rd, 32'd0);
        chk("rst/mem_req", 32'(mem_req), 32'd0);
        chk("rst/mem_we", 32'(mem_we), 32'd0);
        chk("rst/mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst/mem_addr", mem_addr, 32'd0);
        chk("rst/mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst/in_ready", 32'(in_ready), 32'd1);

        // Ack while idle must not start anything
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ack/out_valid", 32'(out_valid), 32'd0);
            chk("idle_ack/mem_req", 32'(mem_req), 32'd0);
        end
        mem_ack = 1'b0;

        for (int i = 0; i < 16; i++)
            run(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 300; i++) begin
            rv.we    = 1'($urandom);
            rv.ctr   = 3'($urandom);
            rv.addr  = $urandom;
            rv.wd    = $urandom;
            rv.rdata = $urandom;
            rv.delay = int'($urandom_range(0, 5));
            rv.rdy   = int'($urandom_range(0, 3));
            rv.maddr = rv.addr & 32'hFFFFFFFC;
            model(rv.we, rv.ctr, rv.addr, rv.wd, rv.rdata, rv.delay,
                  rv.err, rv.rd, rv.reqs, rv.wstrb, rv.wdata);
            run(rv, $sformatf("rnd%0d", i));
        end

        // Reset while a request is outstanding
        @(negedge clk);
        in_valid = 1'b1; in_we = 1'b0; in_ctr = 3'b010; in_addr = 32'h40;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_req/mem_req_before", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req/mem_req_async", 32'(mem_req), 32'd0);
        chk("rst_req/out_valid", 32'(out_valid), 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b0;
        chk("rst_req/in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_req/no_resp", 32'(out_valid), 32'd0);
            chk("rst_req/no_req", 32'(mem_req), 32'd0);
        end

        // Reset while a response is pending
        in_valid = 1'b1; in_we = 1'b0; in_ctr = 3'b111; in_addr = 32'h0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_resp/valid_before", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_resp/valid_async", 32'(out_valid), 32'd0);
        chk("rst_resp/err_async", 32'(out_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_resp/no_resp", 32'(out_valid), 32'd0);
        chk("rst_resp/in_ready", 32'(in_ready), 32'd1);

        // Normal traffic still works after the abandoned accesses
        run(tbl[0], "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
